blk_mem_gen: RTL and testbench

BLK_MEM_GEN -- requirements
Module: blk_mem_gen

---
 rtl/blk_mem_gen.sv | 71 +++++++
 tb/tb_blk_mem_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/blk_mem_gen.sv
// Single-port DEPTH x 1-bit block RAM, read-first, 1-cycle registered read.
// Define BLK_MEM_GEN_OUTREG_EN to add a second output register (2-cycle read).
module blk_mem_gen #(
    parameter int                ADDR_WIDTH = 4,
    parameter int                DEPTH      = 16,
    parameter logic [DEPTH-1:0]  INIT_VALUE = 16'hB2D9
) (
    input  logic                  clock_100Mhz,
    input  logic                  reset,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic                  dina,
    output logic                  douta
);

    logic [DEPTH-1:0] mem_r;
    logic [DEPTH-1:0] sel_s;
    logic             rd_bit_s;
    logic             dout1_r;

    // One-hot word select; addresses at or beyond DEPTH select nothing, so they read 0 and never write.
    always_comb begin
        sel_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            sel_s[i] = (addra == ADDR_WIDTH'(i));
        end
        rd_bit_s = |(sel_s & mem_r);
    end

    // Storage array: reset reloads the initial image, enabled writes update the selected word.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            mem_r <= INIT_VALUE;
        end else if (ena && wea) begin
            mem_r <= (mem_r & ~sel_s) | (sel_s & {DEPTH{dina}});
        end
    end

    // First read stage samples the pre-write content, which gives read-first behaviour.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            dout1_r <= 1'b0;
        end else if (ena) begin
            dout1_r <= rd_bit_s;
        end
    end

`ifdef BLK_MEM_GEN_OUTREG_EN
    logic ena_d_r;
    logic dout2_r;

    // Second stage advances only behind an enabled first-stage load.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            ena_d_r <= 1'b0;
            dout2_r <= 1'b0;
        end else begin
            ena_d_r <= ena;
            if (ena_d_r) begin
                dout2_r <= dout1_r;
            end
        end
    end

    assign douta = dout2_r;
`else
    assign douta = dout1_r;
`endif

endmodule

// File: tb/tb_blk_mem_gen.sv
// Directed self-checking bench for blk_mem_gen; expected read data is queued
// from a reference memory image when each access is driven.
module tb_blk_mem_gen;

`ifdef BLK_MEM_GEN_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [15:0] INIT = 16'hB2D9;

    logic       clock_100Mhz = 1'b0;
    logic       reset;
    logic       ena;
    logic       wea;
    logic [3:0] addra;
    logic       dina;
    logic       douta;

    typedef struct {
        int         due;
        logic       val;
        logic [3:0] addr;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model_mem;
    logic        last_exp;
    int          cyc;
    int          tests;
    int          fails;

    blk_mem_gen dut (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .ena          (ena),
        .wea          (wea),
        .addra        (addra),
        .dina         (dina),
        .douta        (douta)
    );

    always #5 clock_100Mhz = ~clock_100Mhz;

    task automatic check(input string tag, input logic exp);
        tests++;
        assert (douta === exp) else begin
            fails++;
            $error("FAIL %s: douta=%b expected=%b", tag, douta, exp);
        end
    endtask

    // Drive one cycle, queue the expected read, then compare after the edge.
    task automatic step(input logic e, input logic w, input logic [3:0] a,
                        input logic d, input string tag);
        @(negedge clock_100Mhz);
        ena   = e;
        wea   = w;
        addra = a;
        dina  = d;
        if (e && !reset) begin
            sb.push_back('{cyc + LAT, model_mem[a], a});
            if (w) model_mem[a] = d;
        end
        @(posedge clock_100Mhz);
        #1;
        cyc++;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            last_exp = sb[0].val;
            check($sformatf("%s_a%0d", tag, sb[0].addr), sb[0].val);
            void'(sb.pop_front());
        end else begin
            check($sformatf("%s_hold", tag), last_exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        model_mem = INIT;
        last_exp  = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;
        reset = 1'b1;
        ena   = 1'b0;
        wea   = 1'b0;
        addra = 4'd0;
        dina  = 1'b0;
        model_reset();
        #1;
        check("reset_init", 1'b0);
        repeat (2) @(posedge clock_100Mhz);
        @(negedge clock_100Mhz);
        reset = 1'b0;

        // Full initial image, back to back
        for (int a = 0; a < 16; a++) step(1'b1, 1'b0, 4'(a), 1'b0, "init_rd");

        // Read-first write then read-back
        step(1'b1, 1'b1, 4'd3, 1'b0, "wr_old");
        step(1'b1, 1'b0, 4'd3, 1'b0, "rd_new");

        // Disabled port ignores write attempts
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 4'd5, 1'b0, "dis5");
        step(1'b1, 1'b0, 4'd5, 1'b0, "rd5");
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 4'd6, 1'b0, "dis6");
        step(1'b1, 1'b0, 4'd6, 1'b0, "rd6");

        // Mixed back-to-back writes and reads
        step(1'b1, 1'b1, 4'd10, 1'b1, "wr10");
        step(1'b1, 1'b1, 4'd15, 1'b0, "wr15");
        step(1'b1, 1'b0, 4'd10, 1'b0, "rd10");
        step(1'b1, 1'b0, 4'd15, 1'b0, "rd15");
        step(1'b1, 1'b1, 4'd8, 1'b1, "wr8a");
        step(1'b1, 1'b1, 4'd8, 1'b0, "wr8b");
        step(1'b1, 1'b0, 4'd8, 1'b0, "rd8");
        for (int k = 0; k < LAT; k++) step(1'b0, 1'b0, 4'd0, 1'b0, "drain");

        // Mid-cycle async reset after a write to word 0
        step(1'b1, 1'b1, 4'd0, 1'b0, "wr0");
        for (int k = 1; k < LAT; k++) step(1'b0, 1'b0, 4'd0, 1'b0, "wr0_lat");
        #2;
        reset = 1'b1;
        #1;
        check("reset_async_clear", 1'b0);
        model_reset();
        step(1'b1, 1'b1, 4'd4, 1'b0, "in_reset_wr");
        step(1'b1, 1'b0, 4'd4, 1'b0, "in_reset_rd");
        @(negedge clock_100Mhz);
        reset = 1'b0;
        step(1'b1, 1'b0, 4'd0, 1'b0, "rst_rd0");
        step(1'b1, 1'b0, 4'd4, 1'b0, "rst_rd4");
        step(1'b1, 1'b0, 4'd3, 1'b0, "rst_rd3");
        step(1'b1, 1'b0, 4'd10, 1'b0, "rst_rd10");
        step(1'b1, 1'b0, 4'd1, 1'b0, "rst_rd1");
        for (int k = 0; k < LAT; k++) step(1'b0, 1'b0, 4'd0, 1'b0, "drain2");

        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL sb_empty: pending=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
